// File: rtl/sound_code_queue.sv
// Key-code FIFO between the keypad decoder and the synthesizer.
// Requests are answered with the oldest queued code over a four-phase handshake.
module sound_code_queue #(
    parameter int CODE_W = 3,
    parameter int DEPTH  = 4,
    parameter bit REPLAY = 1'b0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CODE_W-1:0]            key_data,
    input  logic                         key_en,
    input  logic                         data_request,
    output logic [CODE_W-1:0]            sound_code,
    output logic                         data_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow,
    input  logic                         clear_overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [CODE_W-1:0]      fifo_r [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic [CNT_W-1:0]       count_next_s;
    logic [CODE_W-1:0]      code_r;
    logic                   overflow_r;
    logic                   overflow_next_s;
    logic                   last_valid_r;
    logic                   pop_s;
    logic                   push_s;
    logic                   overflow_set_s;
    logic                   not_empty_s;

    assign not_empty_s = (count_r != CNT_ZERO);

    // Handshake FSM next-state and pop decision; pops only from the registered count
    always_comb begin
        next_state_s = ST_IDLE;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (data_request && not_empty_s) begin
                    pop_s        = 1'b1;
                    next_state_s = ST_PRESENT;
                end else if (data_request && REPLAY && last_valid_r) begin
                    next_state_s = ST_PRESENT;
                end else if (data_request) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!data_request) begin
                    next_state_s = ST_IDLE;
                end else if (not_empty_s) begin
                    pop_s        = 1'b1;
                    next_state_s = ST_PRESENT;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_PRESENT: begin
                if (!data_request) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_PRESENT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                pop_s        = 1'b0;
            end
        endcase
    end

    // Push acceptance, occupancy update and sticky overflow next value
    always_comb begin
        push_s          = 1'b0;
        overflow_set_s  = 1'b0;
        count_next_s    = count_r;
        overflow_next_s = overflow_r;
        if (key_en && ((count_r < DEPTH_C) || pop_s)) begin
            push_s = 1'b1;
        end else if (key_en) begin
            overflow_set_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
        // clearing wins over a same-cycle overflow event
        if (clear_overflow) begin
            overflow_next_s = 1'b0;
        end else if (overflow_set_s) begin
            overflow_next_s = 1'b1;
        end else begin
            overflow_next_s = overflow_r;
        end
    end

    // Handshake state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FIFO storage; entries are written only on an accepted push
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= {CODE_W{1'b0}};
            end
        end else if (push_s) begin
            fifo_r[wr_ptr_r] <= key_data;
        end else begin
            fifo_r[wr_ptr_r] <= fifo_r[wr_ptr_r];
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
        end
    end

    // Presented code and replay flag change only on a pop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            code_r       <= {CODE_W{1'b0}};
            last_valid_r <= 1'b0;
        end else if (pop_s) begin
            code_r       <= fifo_r[rd_ptr_r];
            last_valid_r <= 1'b1;
        end else begin
            code_r       <= code_r;
            last_valid_r <= last_valid_r;
        end
    end

    // Sticky overflow flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_next_s;
        end
    end

    assign sound_code = code_r;
    assign data_ready = (state_r == ST_PRESENT);
    assign fifo_count = count_r;
    assign overflow   = overflow_r;

endmodule

// File: doc/sound_code_queue.md
# sound_code_queue

Parametrised key-to-synthesizer handshake block with a key-code FIFO. It sits between the keypad decoder and the synthesizer. Key presses (key_en strobes) are queued rather than accepted only while a request is pending. Each synthesizer request is answered with the oldest queued code over a four-phase request/ready handshake, with an optional replay-last-code mode and sticky overflow reporting.

## Interface
- CODE_W, default 3: width of a key/sound code.
- DEPTH, default 4: FIFO entries; power of two, ≥ 2.
- REPLAY, default 0: 1 = on a request with an empty FIFO, re-present the last delivered code instead of waiting.
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; asserting (0) clears all state immediately.
- key_data  input  CODE_W  code from the keypad decoder; sampled when key_en = 1.
- key_en  input  1  single-cycle strobe: push key_data.
- data_request  input  1  synthesizer request; held high until data_ready is seen, then dropped.
- sound_code  output  CODE_W  registered code presented to the synthesizer.
- data_ready  output  1  code on sound_code is valid; decoded from the state register only.
- fifo_count  output  $clog2(DEPTH+1)  number of queued codes.
- overflow  output  1  sticky: a key_en arrived while the FIFO was full and could not be accepted.
- clear_overflow  input  1  synchronous clear of overflow.

## Operation
- FIFO: circular buffer, DEPTH entries, write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. fifo_count is tracked separately, range 0..DEPTH.
- Push: accepted when key_en = 1 and (fifo_count < DEPTH or a pop occurs in the same cycle).
- Full, key_en = 1, no pop: code dropped (newest lost), overflow ← 1.
- clear_overflow has priority over a same-cycle overflow set; overflow reads 0 next cycle.
- Pop: only when the registered fifo_count > 0. There is no same-cycle bypass from key_data to sound_code.
- Simultaneous push and pop: fifo_count is unchanged, and both pointers advance.
- last_valid: internal flag, set on the first pop after reset.
- FSM states: IDLE, WAIT, PRESENT. Encoding is free; unused encodings go to IDLE.
- IDLE (data_ready = 0):
  - data_request = 1 and fifo_count > 0 → pop; sound_code ← head; go to PRESENT.
  - else data_request = 1, REPLAY = 1 and last_valid = 1 → go to PRESENT; sound_code holds.
  - else data_request = 1 → go to WAIT.
- WAIT (data_ready = 0):
  - data_request = 0 → IDLE (request withdrawn; nothing popped).
  - else fifo_count > 0 → pop; sound_code ← head; go to PRESENT.
- PRESENT (data_ready = 1): data_request = 0 → IDLE; otherwise stay.
- sound_code changes only on a pop; it holds between pops and through reset release.

## Timing
- Reset values: sound_code = 0, data_ready = 0, fifo_count = 0, overflow = 0, state = IDLE, pointers = 0, last_valid = 0.
- Request latency from IDLE with a non-empty FIFO: data_request high in cycle t → data_ready = 1 and the new sound_code both valid in cycle t+1.
- Key latency while in WAIT: key_en in cycle t → fifo_count = 1 in t+1 → pop at the end of t+1 → data_ready = 1 in t+2.
- data_request falls in cycle t → data_ready = 0 in t+1. A new request is honoured no earlier than t+1 (IDLE evaluation).
- Back-to-back transfers: one code per request cycle minimum; a full request/ready/drop/ready-low handshake takes ≥ 3 cycles.
- Reset asserted mid-handshake: data_ready drops asynchronously, the FIFO empties, and a pending request restarts from IDLE after release.
- Reset release is synchronised externally; the block applies no deassertion filtering of its own.

## Test plan
- Reset then idle (DEPTH=4): push 3,5,1 with no request → fifo_count = 3, data_ready = 0, sound_code = 0.
- Drain: from the previous state, three request/drop handshakes → sound_code = 3, 5, 1 in order; data_ready one cycle after each request; fifo_count ends at 0.
- Wait path: request with an empty FIFO and REPLAY=0 → WAIT, data_ready = 0. key_en with code 6 → data_ready = 1 two cycles later with sound_code = 6.
- Overflow:
  - Push 5 codes with no request → fifo_count = 4, overflow = 1; codes 1–4 retained, 5th dropped.
  - A request pop in the same cycle as a push on full → no overflow; fifo_count stays 4.
  - clear_overflow → overflow = 0.
- Replay (REPLAY=1): deliver code 2, then request with an empty FIFO → data_ready next cycle, sound_code = 2, fifo_count = 0.
- Abort and reset:
  - Request withdrawn in WAIT → IDLE, nothing popped.
  - reset low during PRESENT → data_ready = 0 and fifo_count = 0 immediately, without waiting for a clock edge.
